// File: rtl/fft_frame_buffer.sv
// Ping-pong sample store: streams packed complex samples into one bank while the other bank
// presents a full NPTS-point frame to the FFT. Optional FRAME_ABORT_EN adds an i_abort input.
module fft_frame_buffer #(
    parameter int WIDTH = 8,
    parameter int NPTS  = 4,
    parameter int IN_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef FRAME_ABORT_EN
    input  logic                       i_abort,
`endif
    input  logic                       i_ena,
    input  logic                       i_load_valid,
    output logic                       o_load_ready,
    input  logic [IN_W-1:0]            i_data_in,
    output logic [$clog2(NPTS+1)-1:0]  o_fill_level,
    output logic                       o_out_valid,
    input  logic                       i_out_done,
    output logic [WIDTH*NPTS-1:0]      o_real_out,
    output logic [WIDTH*NPTS-1:0]      o_imag_out,
    output logic [0:0]                 o_dbg_state
);
    localparam int FW = $clog2(NPTS+1);
    localparam int AW = $clog2(NPTS);
    localparam int H  = IN_W / 2;
    localparam logic [FW-1:0] LAST_PTR = FW'(NPTS - 1);
    localparam logic [FW-1:0] FULL_PTR = FW'(NPTS);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_FULL = 1'b1;

    // Handshake: a sample transfers on a rising clk edge where i_load_valid && o_load_ready;
    // o_load_ready depends only on i_ena and state, never on i_load_valid.

    logic [WIDTH-1:0] r_re [2][NPTS];
    logic [WIDTH-1:0] r_im [2][NPTS];
    logic [0:0]       r_state;
    logic             r_wr_bank;
    logic [FW-1:0]    r_wr_ptr;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_re;
    logic [WIDTH-1:0] w_im;
    logic             w_abort;
    logic             w_accept;
    logic             w_last;
    logic [AW-1:0]    w_wr_idx;
    logic             w_rd_bank;

    // Sign extension followed by a left shift of WIDTH-H is just the half placed in the MSBs.
    always_comb begin
        w_re = '0;
        w_im = '0;
        w_re[WIDTH-1 -: H] = i_data_in[IN_W-1 -: H];
        w_im[WIDTH-1 -: H] = i_data_in[H-1:0];
    end

`ifdef FRAME_ABORT_EN
    assign w_abort = i_ena && i_abort && (r_state == S_FILL);
`else
    assign w_abort = 1'b0;
`endif

    assign o_load_ready = i_ena && (r_state == S_FILL);
    assign w_accept     = i_load_valid && o_load_ready && !w_abort;
    assign w_last       = (r_wr_ptr == LAST_PTR);
    assign w_wr_idx     = r_wr_ptr[AW-1:0];
    assign w_rd_bank    = ~r_wr_bank;
    assign o_fill_level = r_wr_ptr;
    assign o_out_valid  = r_out_valid;
    assign o_dbg_state  = r_state;

    for (genvar g = 0; g < NPTS; g++) begin : g_out
        assign o_real_out[g*WIDTH +: WIDTH] = r_re[w_rd_bank][g];
        assign o_imag_out[g*WIDTH +: WIDTH] = r_im[w_rd_bank][g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NPTS; i++) begin
                    r_re[b][i] <= '0;
                    r_im[b][i] <= '0;
                end
            end
            r_state     <= S_FILL;
            r_wr_bank   <= 1'b0;
            r_wr_ptr    <= '0;
            r_out_valid <= 1'b0;
        end else if (i_ena) begin
            if (r_state == S_FILL) begin
                if (w_accept) begin
                    r_re[r_wr_bank][w_wr_idx] <= w_re;
                    r_im[r_wr_bank][w_wr_idx] <= w_im;
                end
                if (w_abort) begin
                    r_wr_ptr <= '0;
                end else if (w_accept && w_last) begin
                    // Swap immediately when the read bank is free or being released this cycle.
                    if (!r_out_valid || i_out_done) begin
                        r_wr_bank   <= ~r_wr_bank;
                        r_out_valid <= 1'b1;
                        r_wr_ptr    <= '0;
                    end else begin
                        r_state  <= S_FULL;
                        r_wr_ptr <= FULL_PTR;
                    end
                end else if (w_accept) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (i_out_done && !(w_accept && w_last))
                    r_out_valid <= 1'b0;
            end else if (i_out_done) begin
                r_wr_bank <= ~r_wr_bank;
                r_wr_ptr  <= '0;
                r_state   <= S_FILL;
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer (WIDTH=8, NPTS=4, IN_W=8); covers abort when FRAME_ABORT_EN is set.
module tb_fft_frame_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_abort;
    logic        i_ena;
    logic        i_load_valid;
    logic        o_load_ready;
    logic [7:0]  i_data_in;
    logic [2:0]  o_fill_level;
    logic        o_out_valid;
    logic        i_out_done;
    logic [31:0] o_real_out;
    logic [31:0] o_imag_out;
    logic [0:0]  o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fft_frame_buffer #(.WIDTH(8), .NPTS(4), .IN_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef FRAME_ABORT_EN
        .i_abort      (i_abort),
`endif
        .i_ena        (i_ena),
        .i_load_valid (i_load_valid),
        .o_load_ready (o_load_ready),
        .i_data_in    (i_data_in),
        .o_fill_level (o_fill_level),
        .o_out_valid  (o_out_valid),
        .i_out_done   (i_out_done),
        .o_real_out   (o_real_out),
        .o_imag_out   (o_imag_out),
        .o_dbg_state  (o_dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        i_load_valid = 1'b1;
        i_data_in    = d;
        tick();
        i_load_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_abort = 1'b0; i_ena = 1'b1; i_load_valid = 1'b0;
        i_data_in = '0; i_out_done = 1'b0;
        #22;
        check("rst_valid", o_out_valid, 0);
        check("rst_fill", o_fill_level, 0);
        check("rst_real", o_real_out, 0);
        check("rst_imag", o_imag_out, 0);
        rst = 1'b0;
        tick();
        check("rst_ready", o_load_ready, 1);

        // out_done with nothing valid is ignored
        i_out_done = 1'b1; tick(); i_out_done = 1'b0;
        check("done_idle_valid", o_out_valid, 0);

        // Frame A: conversion and fill level
        send(8'h1F); check("a_fill1", o_fill_level, 1);
        send(8'h7F); check("a_fill2", o_fill_level, 2);
        send(8'h80); check("a_fill3", o_fill_level, 3);
        check("a_valid_pre", o_out_valid, 0);
        send(8'h08);
        check("a_valid", o_out_valid, 1);
        check("a_fill0", o_fill_level, 0);
        check("a_real", o_real_out, 32'h0080_7010);
        check("a_imag", o_imag_out, 32'h8000_F0F0);

        // Frame B while A unconsumed -> FULL
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        check("b_ready_full", o_load_ready, 0);
        check("b_fill_full", o_fill_level, 4);
        check("b_state_full", o_dbg_state, 1);
        check("b_real_still_a", o_real_out, 32'h0080_7010);
        send(8'h99);  // refused while FULL
        check("b_fill_hold", o_fill_level, 4);
        i_out_done = 1'b1; tick(); i_out_done = 1'b0;
        check("b_valid", o_out_valid, 1);
        check("b_ready", o_load_ready, 1);
        check("b_fill0", o_fill_level, 0);
        check("b_real", o_real_out, 32'h4030_2010);
        check("b_imag", o_imag_out, 32'h4030_2010);

        // Frame C: last sample coincides with out_done -> zero-bubble swap
        send(8'h55); send(8'h66); send(8'h77);
        i_out_done = 1'b1; send(8'h12); i_out_done = 1'b0;
        check("c_valid", o_out_valid, 1);
        check("c_ready", o_load_ready, 1);
        check("c_state", o_dbg_state, 0);
        check("c_real", o_real_out, 32'h1070_6050);
        check("c_imag", o_imag_out, 32'h2070_6050);

        // Release C without a completing write -> stale outputs
        i_out_done = 1'b1; tick(); i_out_done = 1'b0;
        check("rel_valid", o_out_valid, 0);
        check("rel_stale", o_real_out, 32'h1070_6050);

        // ena=0 freezes everything mid-frame
        send(8'h01); send(8'h02);
        i_ena = 1'b0; i_load_valid = 1'b1; i_data_in = 8'h03; i_out_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ena0_fill", o_fill_level, 2);
            check("ena0_ready", o_load_ready, 0);
            check("ena0_real", o_real_out, 32'h1070_6050);
        end
        i_load_valid = 1'b0; i_out_done = 1'b0; i_ena = 1'b1;
        send(8'h03); check("ena1_fill", o_fill_level, 3);
        send(8'h04);
        check("d_valid", o_out_valid, 1);
        check("d_real", o_real_out, 32'h0000_0000);
        check("d_imag", o_imag_out, 32'h4030_2010);

        // Async reset mid-frame with a valid frame pending
        send(8'h7F); send(8'h7F);
        check("r_fill2", o_fill_level, 2);
        #3 rst = 1'b1;
        #1;
        check("r_valid", o_out_valid, 0);
        check("r_fill", o_fill_level, 0);
        check("r_real", o_real_out, 0);
        check("r_imag", o_imag_out, 0);
        #2 rst = 1'b0;
        tick();

`ifdef FRAME_ABORT_EN
        send(8'h7F); send(8'h7F); send(8'h7F);
        i_abort = 1'b1; send(8'h66); i_abort = 1'b0;
        check("ab_fill", o_fill_level, 0);
        check("ab_valid", o_out_valid, 0);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        check("ab_frame_valid", o_out_valid, 1);
        check("ab_real", o_real_out, 32'h4030_2010);
        check("ab_imag", o_imag_out, 32'h4030_2010);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
